rx_decode_scheduler: RTL

//  Shares one 15-bit CRC/parity correction decoder among NREQ receive channels.
//  - Round-robin arbitration across the channels.
//  - Issues at most one codeword per cycle into the shared decoder.
//  - Carries a tag pipeline, so each corrected word and its error flag return to the issuing channel.
//  - Sits between the per-channel receive FIFOs and the decoder instance.

---
 rtl/rx_decode_scheduler_if.sv | 25 ++
 rtl/rx_decode_scheduler.sv | 116 +++++++++++
 2 files changed

// File: rtl/rx_decode_scheduler_if.sv
// Channel-side bus of rx_decode_scheduler: per-channel codeword requests and tagged responses.
`timescale 1ns/1ps
interface rx_decode_scheduler_if #(
  parameter int NREQ = 4
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]    req_valid;
  logic [NREQ*15-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic               resp_valid;
  logic [IDW-1:0]     resp_id;
  logic [14:0]        resp_data;
  logic               resp_err;

  modport master (
    output req_valid, req_data,
    input  req_ready, resp_valid, resp_id, resp_data, resp_err
  );

  modport slave (
    input  req_valid, req_data,
    output req_ready, resp_valid, resp_id, resp_data, resp_err
  );
endinterface

// File: rtl/rx_decode_scheduler.sv
// Round-robin scheduler sharing one 15-bit correction decoder among NREQ channels, with a tag pipeline.
// Define RX_SCHED_STATS_EN to add per-channel saturating error counters (stat_clr / stat_err).
`timescale 1ns/1ps
module rx_decode_scheduler #(
  parameter int NREQ    = 4,
  parameter int DEC_LAT = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               flush,
  rx_decode_scheduler_if.slave rx,
  output logic [14:0]        dec_data_re,
  input  logic [14:0]        dec_data_out,
  input  logic               dec_error,
`ifdef RX_SCHED_STATS_EN
  input  logic               stat_clr,
  output logic [NREQ*8-1:0]  stat_err,
`endif
  output logic               busy
);
  localparam int IDW = $clog2(NREQ);
  localparam int PW  = IDW + 1;

  logic [IDW-1:0]  rr_ptr;
  logic [IDW-1:0]  grant_id;
  logic [NREQ-1:0] grant;
  logic            found;
  logic [PW-1:0]   pos;
  logic [14:0]     grant_word;
  logic            xfer;
  logic [DEC_LAT-1:0] tag_valid;
  logic [IDW-1:0]  tag_id [DEC_LAT];

  // Search starts at rr_ptr and wraps; pos carries one spare bit so the wrap works for any NREQ.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    pos      = '0;
    for (int k = 0; k < NREQ; k++) begin
      pos = {1'b0, rr_ptr} + PW'(k);
      if (pos >= PW'(NREQ))
        pos = pos - PW'(NREQ);
      if (!found && rx.req_valid[pos[IDW-1:0]]) begin
        found               = 1'b1;
        grant[pos[IDW-1:0]] = 1'b1;
        grant_id            = pos[IDW-1:0];
      end
    end
  end

  assign rx.req_ready = (en && !flush && !reset) ? grant : '0;
  assign xfer         = |rx.req_ready;

  always_comb begin
    grant_word = '0;
    for (int i = 0; i < NREQ; i++)
      if (grant[i])
        grant_word = rx.req_data[15*i +: 15];
  end

  // Issue register and tag shift chain; flush only kills tags, the decoder data path keeps shifting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr      <= '0;
      dec_data_re <= '0;
      tag_valid   <= '0;
      for (int s = 0; s < DEC_LAT; s++)
        tag_id[s] <= '0;
    end else begin
      dec_data_re  <= xfer ? grant_word : 15'd0;
      if (xfer)
        rr_ptr <= (grant_id == IDW'(NREQ-1)) ? '0 : grant_id + IDW'(1);
      tag_valid[0] <= xfer;
      tag_id[0]    <= xfer ? grant_id : '0;
      for (int s = 1; s < DEC_LAT; s++) begin
        tag_valid[s] <= tag_valid[s-1];
        tag_id[s]    <= tag_id[s-1];
      end
      if (flush)
        tag_valid <= '0;
    end
  end

  assign rx.resp_valid = tag_valid[DEC_LAT-1];
  assign rx.resp_id    = tag_valid[DEC_LAT-1] ? tag_id[DEC_LAT-1] : '0;
  assign rx.resp_data  = tag_valid[DEC_LAT-1] ? dec_data_out : 15'd0;
  assign rx.resp_err   = tag_valid[DEC_LAT-1] & dec_error;
  assign busy          = |tag_valid;

`ifdef RX_SCHED_STATS_EN
  logic [7:0] err_cnt [NREQ];

  // Clear wins over a same-cycle increment; counters stick at 255.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREQ; i++)
        err_cnt[i] <= '0;
    end else if (stat_clr) begin
      for (int i = 0; i < NREQ; i++)
        err_cnt[i] <= '0;
    end else if (rx.resp_valid && rx.resp_err) begin
      for (int i = 0; i < NREQ; i++)
        if (rx.resp_id == IDW'(i) && err_cnt[i] != 8'hff)
          err_cnt[i] <= err_cnt[i] + 8'd1;
    end
  end

  always_comb begin
    stat_err = '0;
    for (int i = 0; i < NREQ; i++)
      stat_err[8*i +: 8] = err_cnt[i];
  end
`endif
endmodule
